// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: default width, opcodes, FSM states.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_NOR   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_NOT_A = 3'b110;
    localparam logic [2:0] OP_ADD   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the response consumer.
interface alu_arbiter_if #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_A;
    logic [WIDTH-1:0] req0_B;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_A;
    logic [WIDTH-1:0] req1_B;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;

    modport master (
        output req0_valid, req0_op, req0_A, req0_B,
        output req1_valid, req1_op, req1_A, req1_B,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req0_valid, req0_op, req0_A, req0_B,
        input  req1_valid, req1_op, req1_A, req1_B,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu_logic_unit.sv
// Combinational logic/add unit shared by both requesters.
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_NOR:   o_result = ~(i_a | i_b);
            OP_XOR:   o_result = i_a ^ i_b;
            OP_NAND:  o_result = ~(i_a & i_b);
            OP_XNOR:  o_result = ~(i_a ^ i_b);
            OP_NOT_A: o_result = ~i_a;
            OP_ADD:   o_result = i_a + i_b;
            default:  o_result = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU, one transaction in flight (IDLE -> EXEC -> RESP).
// Optional ALU_ARBITER_STATS_EN adds saturating per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [7:0]   grant_cnt0,
    output logic [7:0]   grant_cnt1
`endif
);
    state_e           r_state;
    state_e           w_next_state;
    logic             r_ptr;
    logic             r_id;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_grant;
    logic             w_grant_id;

    alu_logic_unit #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result)
    );

    // Readies are masked by rst so they drop the instant reset is asserted.
    always_comb begin
        w_next_state   = r_state;
        w_grant        = 1'b0;
        w_grant_id     = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant_id = (bus.req0_valid && bus.req1_valid) ? r_ptr : bus.req1_valid;
                w_grant    = (bus.req0_valid || bus.req1_valid) && !rst;
                if (w_grant) begin
                    w_next_state   = ST_EXEC;
                    bus.req0_ready = !w_grant_id;
                    bus.req1_ready = w_grant_id;
                end
            end
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 1'b0;
            r_id     <= 1'b0;
            r_op     <= OP_AND;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_id <= w_grant_id;
                r_op <= w_grant_id ? bus.req1_op : bus.req0_op;
                r_a  <= w_grant_id ? bus.req1_A  : bus.req0_A;
                r_b  <= w_grant_id ? bus.req1_B  : bus.req0_B;
            end
            if (r_state == ST_EXEC)
                r_result <= w_alu_result;
            if (r_state == ST_RESP && bus.rsp_ready)
                r_ptr <= ~r_id;
        end
    end

    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;

`ifdef ALU_ARBITER_STATS_EN
    logic [7:0] r_grant_cnt0;
    logic [7:0] r_grant_cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt0 <= 8'd0;
            r_grant_cnt1 <= 8'd0;
        end else if (w_grant) begin
            if (!w_grant_id && r_grant_cnt0 != 8'hFF) r_grant_cnt0 <= r_grant_cnt0 + 8'd1;
            if (w_grant_id && r_grant_cnt1 != 8'hFF)  r_grant_cnt1 <= r_grant_cnt1 + 8'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle plus directed literal vectors.
// Covers the ALU_ARBITER_STATS_EN counters when that macro is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_arbiter_if #(.WIDTH(W)) bus ();

`ifdef ALU_ARBITER_STATS_EN
    logic [7:0] cnt0, cnt1;
`endif

    alu_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .grant_cnt0 (cnt0),
        .grant_cnt1 (cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input int a, input int b);
        int r;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~(a | b);
            3'd3: r = a ^ b;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a ^ b);
            3'd6: r = ~a;
            default: r = (a + b) % (1 << W);
        endcase
        return r[W-1:0];
    endfunction

    // Transaction-level model: one job in flight, response visible from the 2nd cycle after accept.
    bit           m_busy = 0;
    int           m_age  = 0;
    bit           m_ptr  = 0;
    bit           m_id   = 0;
    logic [W-1:0] m_res  = '0;
    int           m_cnt0 = 0;
    int           m_cnt1 = 0;
    bit           e_r0, e_r1;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (!m_busy) begin
            e_r0 = bus.req0_valid && (!bus.req1_valid || m_ptr == 1'b0);
            e_r1 = bus.req1_valid && (!bus.req0_valid || m_ptr == 1'b1);
            check("m_ready0", bus.req0_ready, e_r0);
            check("m_ready1", bus.req1_ready, e_r1);
            check("m_rsp_valid_idle", bus.rsp_valid, 0);
            if (e_r0 || e_r1) begin
                m_id   = e_r1;
                m_res  = e_r1 ? alu_ref(bus.req1_op, int'(bus.req1_A), int'(bus.req1_B))
                              : alu_ref(bus.req0_op, int'(bus.req0_A), int'(bus.req0_B));
                m_busy = 1;
                m_age  = 0;
                if (e_r1) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
                else      m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            end
        end else begin
            m_age++;
            check("m_ready_busy", {bus.req0_ready, bus.req1_ready}, 0);
            check("m_rsp_valid", bus.rsp_valid, m_age >= 2);
            if (m_age >= 2) begin
                check("m_rsp_id", bus.rsp_id, m_id);
                check("m_rsp_result", bus.rsp_result, m_res);
                if (bus.rsp_ready) begin
                    m_busy = 0;
                    m_ptr  = !m_id;
                end
            end
        end
    end

    // Called just after a rising edge; returns once the response has been handshaked.
    task automatic run_one(input bit id, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, output logic rid, output logic [W-1:0] res,
                           output int wait_cyc, output int lat);
        if (id) begin
            bus.req1_op = op; bus.req1_A = a; bus.req1_B = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_A = a; bus.req0_B = b; bus.req0_valid = 1'b1;
        end
        wait_cyc = 0;
        @(negedge clk);
        while (!(id ? bus.req1_ready : bus.req0_ready) && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (wait_cyc >= 20) check("ready_timeout", 1, 0);
        @(posedge clk); #1;
        if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("rsp_timeout", 1, 0);
        rid = bus.rsp_id;
        res = bus.rsp_result;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit           id;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vecs[10];
    logic         rid;
    logic [W-1:0] res;
    int           wc, lat, cyc, last, gcount;
    bit           exp_id;

    initial begin
        vecs[0] = '{0, OP_NOR,   4'b1001, 4'b1010, 4'b0100};
        vecs[1] = '{1, OP_NOR,   4'b0000, 4'b1111, 4'b0000};
        vecs[2] = '{1, OP_ADD,   4'b1111, 4'b0001, 4'b0000};
        vecs[3] = '{0, OP_AND,   4'b1100, 4'b1010, 4'b1000};
        vecs[4] = '{1, OP_OR,    4'b1100, 4'b1010, 4'b1110};
        vecs[5] = '{0, OP_XOR,   4'b1100, 4'b1010, 4'b0110};
        vecs[6] = '{1, OP_NAND,  4'b1100, 4'b1010, 4'b0111};
        vecs[7] = '{0, OP_XNOR,  4'b1100, 4'b1010, 4'b1001};
        vecs[8] = '{1, OP_NOT_A, 4'b1100, 4'b1111, 4'b0011};
        vecs[9] = '{0, OP_ADD,   4'b0111, 4'b0101, 4'b1100};

        bus.req0_valid = 1'b1; bus.req0_op = OP_AND; bus.req0_A = '0; bus.req0_B = '0;
        bus.req1_valid = 1'b1; bus.req1_op = OP_AND; bus.req1_A = '0; bus.req1_B = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state, with both valids high to show readies are held off.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;

        // Directed single-requester vectors.
        foreach (vecs[i]) begin
            run_one(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, rid, res, wc, lat);
            check("vec_ready_same_cycle", wc, 0);
            check("vec_latency", lat, 2);
            check("vec_id", rid, vecs[i].id);
            check("vec_result", res, vecs[i].exp);
        end

        // Both valid continuously: grants alternate starting with 0, one every 3 cycles.
        do_reset();
        bus.req0_op = OP_AND; bus.req0_A = 4'hF; bus.req0_B = 4'h5; bus.req0_valid = 1'b1;
        bus.req1_op = OP_OR;  bus.req1_A = 4'h1; bus.req1_B = 4'h2; bus.req1_valid = 1'b1;
        gcount = 0; last = -1; cyc = 0; exp_id = 0;
        while (gcount < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.req0_ready || bus.req1_ready) begin
                check("rr_grant", bus.req1_ready, exp_id);
                exp_id = !exp_id;
                if (last >= 0) check("rr_period", cyc - last, 3);
                last = cyc;
                gcount++;
            end
        end
        if (gcount < 6) check("rr_timeout", gcount, 6);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Consumer stalls five cycles while req1 is waiting.
        bus.rsp_ready = 1'b0;
        bus.req0_op = OP_XOR; bus.req0_A = 4'b0101; bus.req0_B = 4'b0011; bus.req0_valid = 1'b1;
        wc = 0;
        @(negedge clk);
        while (!bus.req0_ready && wc < 20) begin @(negedge clk); wc++; end
        check("stall_accept", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_op = OP_AND; bus.req1_A = 4'b0011; bus.req1_B = 4'b0110; bus.req1_valid = 1'b1;
        wc = 0;
        @(negedge clk);
        while (!bus.rsp_valid && wc < 20) begin @(negedge clk); wc++; end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_id", bus.rsp_id, 0);
            check("stall_result", bus.rsp_result, 4'b0110);
            check("stall_readies", {bus.req0_ready, bus.req1_ready}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("release_valid", bus.rsp_valid, 1);
        check("release_no_ready", bus.req1_ready, 0);
        @(negedge clk);
        check("after_rsp_valid", bus.rsp_valid, 0);
        check("after_rsp_ready1", bus.req1_ready, 1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wc = 0;
        @(negedge clk);
        while (!bus.rsp_valid && wc < 20) begin @(negedge clk); wc++; end
        check("queued_id", bus.rsp_id, 1);
        check("queued_result", bus.rsp_result, 4'b0010);
        @(posedge clk); #1;

        // Reset pulsed during EXEC drops the transaction.
        bus.req1_op = OP_NOR; bus.req1_A = 4'b0000; bus.req1_B = 4'b0000; bus.req1_valid = 1'b1;
        @(negedge clk);
        check("exec_rst_grant", bus.req1_ready, 1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("exec_rst_rsp_valid", bus.rsp_valid, 0);
        check("exec_rst_rsp_id", bus.rsp_id, 0);
        check("exec_rst_rsp_result", bus.rsp_result, 0);
        check("exec_rst_readies", {bus.req0_ready, bus.req1_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("exec_rst_no_rsp", bus.rsp_valid, 0);
        end
        @(posedge clk); #1;

        // 300 grants to req0 (saturates its counter when stats are built in).
        for (int i = 0; i < 300; i++)
            run_one(0, OP_AND, i[3:0], 4'hF, rid, res, wc, lat);
        check("bulk_last_result", res, 4'b1011);
`ifdef ALU_ARBITER_STATS_EN
        check("grant_cnt0_sat", cnt0, 255);
        check("grant_cnt0_model", cnt0, m_cnt0);
        check("grant_cnt1_model", cnt1, m_cnt1);
        check("grant_cnt1_zero", cnt1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
